spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares one SPI master core between two byte-stream requesters using round-robin arbitration.
- Sequences each requester's burst (one or more bytes) into the core: issues start pulses, waits for completion and returns received bytes.
- Owns the active-low slave-select so that a burst is one continuous select window.
- Sits between the processing-side logic and the SPI master core.

Parameters:
DATA_W, 8, transfer width per core operation
GAP_CYCLES, 2, idle cycles with ss high between bursts (min 1)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, asynchronous, active-high
req0  in  1  requester 0 wants / continues a burst
wdata0  in  DATA_W  requester 0 byte to send
last0  in  1  qualifies wdata0 as final byte of burst
ack0  out  1  1-cycle pulse: wdata0/last0 consumed
rvalid0  out  1  1-cycle pulse: rdata holds requester 0 received byte
req1, wdata1, last1, ack1, rvalid1: same as requester 0, for requester 1
rdata  out  DATA_W  shared received byte, valid with rvalid0/rvalid1
core_start  out  1  1-cycle start pulse to SPI core
core_tx  out  DATA_W  byte to core; stable from core_start until core_done
core_done  in  1  1-cycle pulse from core: transfer complete
core_rx  in  DATA_W  core received byte, valid with core_done
ss  out  1  slave select, active low

Behaviour:
- Reset (async, immediate): ss=1; core_start=0; ack*=0; rvalid*=0; rdata=0; core_tx=0; state IDLE; round-robin pointer favours requester 0.
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD, GAP.
- IDLE: ss=1.
  - If any req, grant by round-robin: favour the requester not granted last; after reset, requester 0 wins a tie.
  - Register grant, go to SETUP.
- SETUP: ss=0 for exactly 1 cycle (select setup time), then LOAD.
- LOAD, single cycle:
  - core_start=1 and ackN=1 together.
  - core_tx <= wdataN; capture lastN into last_q.
  - Go to WAIT.
- WAIT: ss=0. On core_done:
  - rdata <= core_rx; rvalidN=1 on the next cycle.
  - If last_q=1: go to GAP.
  - Else if reqN=1: go to LOAD.
  - Else: go to HOLD.
- HOLD: ss stays 0; the other requester stays blocked. When reqN returns high, go to LOAD. A burst is never split by the other requester.
- GAP: ss=1 for GAP_CYCLES cycles (counter), then IDLE. Requests arriving during GAP are held off; the pointer was updated at grant time.
- Latency:
  - req high in IDLE at cycle t → ss low at t+1, core_start/ack at t+2.
  - core_done at cycle d → rvalid at d+1.
  - Next core_start of a continuing burst at d+1.
- Throughput: 1 byte per (core transfer time + 1) cycles within a burst.
- core_done outside WAIT is ignored (no rvalid, no state change).
- The requester must hold wdata/last stable while req=1 and ack has not yet pulsed; data is sampled only in LOAD.
- Dropping req in IDLE before grant cancels the request without side effect.
- Only one of ack0/ack1 and only one of rvalid0/rvalid1 is ever high in a cycle.
- The grant never changes while ss=0.
- Reset mid-burst: ss returns high asynchronously; the core is not notified, and a later core_done is ignored per the rule above.

Test Plan:
- Single byte: after reset, req0=1, wdata0=0xA5, last0=1; core model returns 0x3C after 16 cycles. Required: ss low 1 cycle before core_start; ack0 with core_start; core_tx=0xA5; rvalid0 with rdata=0x3C one cycle after core_done; ss high for 2 cycles, then IDLE.
- Simultaneous: req0 and req1 both high from reset, each sending a single byte with last=1. Required: requester 0 served first, then requester 1; ss returns high for GAP_CYCLES between the two bursts.
- Burst: requester 1 sends 0x11, 0x22, 0x33 with last on 0x33. Required:
  - ss low continuously across all three bytes.
  - 3 ack1 pulses and 3 rvalid1 pulses.
  - core_start for each following byte one cycle after the previous core_done.
- Hold: requester 0 sends byte 1 (last=0), drops req0 for 10 cycles while req1=1, then resumes with a byte marked last. Required: ss stays low throughout; no ack1 until the requester 0 burst ends.
- Fairness: both requesters issue 4 back-to-back single-byte bursts. Required grant order 0,1,0,1,0,1,0,1.
- Reset mid-WAIT: assert rst during a transfer, then pulse core_done after release. Required: ss=1 immediately; no rvalid; state IDLE.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI master core between two byte-stream
// requesters; owns slave-select so each burst is one select window.
module spi_xfer_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              last0,
    output logic              ack0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              last1,
    output logic              ack1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              core_start,
    output logic [DATA_W-1:0] core_tx,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_rx,
    output logic              ss
);

    localparam int CW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            r_state;
    // Current owner; while idle it doubles as the round-robin pointer
    // (the other requester wins a tie).
    logic              r_gnt;
    logic              r_last_q;
    logic [CW-1:0]     r_gap;

    logic              w_req_g;
    logic [DATA_W-1:0] w_wdata_g;
    logic              w_last_g;
    logic              w_pick;
    logic              w_go_load;

    // Mux the granted requester and decide when a byte is handed to the core.
    always_comb begin
        w_req_g   = r_gnt ? req1 : req0;
        w_wdata_g = r_gnt ? wdata1 : wdata0;
        w_last_g  = r_gnt ? last1 : last0;
        w_pick    = (req0 && req1) ? ~r_gnt : req1;
        w_go_load = (r_state == S_SETUP)
                 || ((r_state == S_HOLD) && w_req_g)
                 || ((r_state == S_WAIT) && core_done
                     && !r_last_q && w_req_g);
    end

    // Burst sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b1;
            r_last_q   <= 1'b0;
            r_gap      <= '0;
            ss         <= 1'b1;
            core_start <= 1'b0;
            core_tx    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= '0;
        end else begin
            core_start <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_gnt   <= w_pick;
                        ss      <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: r_state <= S_LOAD;
                S_LOAD:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (core_done) begin
                        rdata   <= core_rx;
                        rvalid0 <= ~r_gnt;
                        rvalid1 <= r_gnt;
                        if (r_last_q) begin
                            ss      <= 1'b1;
                            r_gap   <= GAP_LAST;
                            r_state <= S_GAP;
                        end else if (w_req_g) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_req_g) r_state <= S_LOAD;
                end
                S_GAP: begin
                    if (r_gap == '0) r_state <= S_IDLE;
                    else r_gap <= r_gap - CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_go_load) begin
                core_start <= 1'b1;
                ack0       <= ~r_gnt;
                ack1       <= r_gnt;
                core_tx    <= w_wdata_g;
                r_last_q   <= w_last_g;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: requester queues, a fixed-latency
// core model and an event log checked after each directed step.
module tb_spi_xfer_arbiter;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int LAT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          last0 = 1'b0, last1 = 1'b0;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          core_start;
    logic [DW-1:0] core_tx;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_rx = '0;
    logic          ss;

    spi_xfer_arbiter #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wdata0(wdata0), .last0(last0),
        .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .wdata1(wdata1), .last1(last1),
        .ack1(ack1), .rvalid1(rvalid1),
        .rdata(rdata),
        .core_start(core_start), .core_tx(core_tx),
        .core_done(core_done), .core_rx(core_rx),
        .ss(ss)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] q_rx[$];
    int         q_gnt[$];
    logic [7:0] q_tx[$];
    logic [8:0] q_rv[$];
    int         q_start[$];
    int         q_done[$];
    int         q_fall[$];
    int         q_rise[$];
    int         last_done = -100;
    logic       ss_prev = 1'b1;
    logic       core_en = 1'b1;
    logic       man_done = 1'b0;
    logic       busy = 1'b0;
    int         cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // requester drivers: present queue head, pop on ack
    always @(negedge clk) begin
        if (ack0 && q0.size() > 0) void'(q0.pop_front());
        if (ack1 && q1.size() > 0) void'(q1.pop_front());
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) {last0, wdata0} = q0[0];
        if (req1) {last1, wdata1} = q1[0];
    end

    // core model: done LAT cycles after start, returns queued bytes
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
                busy = 1'b0;
                core_done = 1'b1;
                core_rx = (q_rx.size() > 0) ? q_rx.pop_front() : 8'h00;
                q_done.push_back(cyc);
                last_done = cyc;
            end
        end else if (core_start && core_en) begin
            busy = 1'b1;
            cnt = LAT;
        end
        if (man_done) core_done = 1'b1;
    end

    // event logger with per-cycle invariants
    always @(negedge clk) begin
        if (!rst) begin
            if (ss_prev && !ss) q_fall.push_back(cyc);
            if (!ss_prev && ss) q_rise.push_back(cyc);
            if (core_start) begin
                q_start.push_back(cyc);
                q_tx.push_back(core_tx);
            end
            if (ack0 || ack1) begin
                chk("ack_with_start", core_start, 1);
                chk("ack_onehot", ack0 & ack1, 0);
                q_gnt.push_back(ack1 ? 1 : 0);
            end
            if (rvalid0 || rvalid1) begin
                chk("rv_onehot", rvalid0 & rvalid1, 0);
                chk("rv_latency", cyc, last_done + 1);
                q_rv.push_back({rvalid1, rdata});
            end
        end
        ss_prev = ss;
    end

    task automatic clear_logs();
        q0.delete(); q1.delete(); q_rx.delete();
        q_gnt.delete(); q_tx.delete(); q_rv.delete();
        q_start.delete(); q_done.delete();
        q_fall.delete(); q_rise.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        man_done = 1'b0;
        core_en = 1'b1;
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ss"}, ss, 1);
        chk({tag, "_start"}, core_start, 0);
        chk({tag, "_acks"}, {ack0, ack1}, 0);
        chk({tag, "_rvs"}, {rvalid0, rvalid1}, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_tx"}, core_tx, 0);
    endtask

    task automatic wait_rv(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (q_rv.size() >= n) break;
            @(posedge clk);
        end
        chk(tag, q_rv.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // single byte
        do_reset();
        chk_reset("rst1");
        @(posedge clk); #1;
        q_rx.push_back(8'h3C);
        q0.push_back({1'b1, 8'hA5});
        wait_rv(1, 100, "t1_rv_count");
        repeat (5) @(posedge clk);
        if (q_rv.size() == 1 && q_start.size() == 1 && q_fall.size() == 1) begin
            chk("t1_setup", q_start[0], q_fall[0] + 1);
            chk("t1_gnt", q_gnt[0], 0);
            chk("t1_tx", q_tx[0], 8'hA5);
            chk("t1_rv", q_rv[0], {1'b0, 8'h3C});
            chk("t1_ss_rise", q_rise[0], q_done[0] + 1);
        end else chk("t1_events", q_start.size(), 1);

        // simultaneous single bytes
        do_reset();
        chk_reset("rst2");
        q_rx.push_back(8'hE1);
        q_rx.push_back(8'hE2);
        q0.push_back({1'b1, 8'h01});
        q1.push_back({1'b1, 8'h02});
        wait_rv(2, 200, "t2_rv_count");
        if (q_gnt.size() == 2 && q_fall.size() == 2 && q_rise.size() >= 1) begin
            chk("t2_gnt0", q_gnt[0], 0);
            chk("t2_gnt1", q_gnt[1], 1);
            chk("t2_tx", {q_tx[0], q_tx[1]}, 16'h0102);
            chk("t2_rv", {q_rv[0], q_rv[1]}, {1'b0, 8'hE1, 1'b1, 8'hE2});
            // GAP cycles plus the IDLE grant cycle with ss high
            chk("t2_gap", q_fall[1] - q_rise[0], GAP + 1);
        end else chk("t2_events", q_gnt.size(), 2);

        // three-byte burst from requester 1
        do_reset();
        chk_reset("rst3");
        q_rx.push_back(8'hA1);
        q_rx.push_back(8'hA2);
        q_rx.push_back(8'hA3);
        q1.push_back({1'b0, 8'h11});
        q1.push_back({1'b0, 8'h22});
        q1.push_back({1'b1, 8'h33});
        wait_rv(3, 300, "t3_rv_count");
        repeat (2) @(posedge clk);
        chk("t3_falls", q_fall.size(), 1);
        chk("t3_rises", q_rise.size(), 1);
        chk("t3_acks", q_gnt.size(), 3);
        if (q_gnt.size() == 3 && q_done.size() == 3 && q_rv.size() == 3) begin
            chk("t3_gnt", {q_gnt[0][0], q_gnt[1][0], q_gnt[2][0]}, 3'b111);
            chk("t3_tx", {q_tx[0], q_tx[1], q_tx[2]}, 24'h112233);
            chk("t3_rv", {q_rv[0], q_rv[1], q_rv[2]},
                {1'b1, 8'hA1, 1'b1, 8'hA2, 1'b1, 8'hA3});
            chk("t3_next1", q_start[1], q_done[0] + 1);
            chk("t3_next2", q_start[2], q_done[1] + 1);
        end

        // hold: requester 0 pauses mid-burst while requester 1 waits
        do_reset();
        q_rx.push_back(8'hB0);
        q_rx.push_back(8'hB1);
        q_rx.push_back(8'hB2);
        q0.push_back({1'b0, 8'h40});
        q1.push_back({1'b1, 8'h50});
        wait_rv(1, 100, "t4_rv1");
        repeat (10) @(posedge clk);
        #1 q0.push_back({1'b1, 8'h41});
        wait_rv(3, 300, "t4_rv_count");
        if (q_gnt.size() == 3 && q_done.size() == 3 && q_rise.size() >= 1) begin
            chk("t4_gnt", {q_gnt[0][0], q_gnt[1][0], q_gnt[2][0]}, 3'b001);
            chk("t4_tx", {q_tx[0], q_tx[1], q_tx[2]}, 24'h404150);
            chk("t4_ss_held", q_rise[0], q_done[1] + 1);
            chk("t4_paused", (q_start[1] - q_done[0]) > 10, 1);
            chk("t4_falls", q_fall.size(), 2);
        end else chk("t4_events", q_gnt.size(), 3);

        // fairness: four single-byte bursts each
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'(8'h60 + i)});
            q1.push_back({1'b1, 8'(8'h70 + i)});
        end
        wait_rv(8, 600, "t5_rv_count");
        if (q_gnt.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t5_gnt%0d", i), q_gnt[i], i % 2);
                chk($sformatf("t5_tx%0d", i), q_tx[i],
                    (i % 2 ? 8'h70 : 8'h60) + 8'(i / 2));
            end
        end else chk("t5_events", q_gnt.size(), 8);

        // reset during WAIT, stray core_done afterwards
        do_reset();
        core_en = 1'b0;
        q0.push_back({1'b1, 8'h99});
        for (int i = 0; i < 50; i++) begin
            if (q_start.size() >= 1) break;
            @(posedge clk);
        end
        chk("t6_started", q_start.size(), 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("t6_ss_async", ss, 1);
        chk_reset("t6_rst");
        clear_logs();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        repeat (5) @(posedge clk);
        chk("t6_no_rv", q_rv.size(), 0);
        chk("t6_no_start", q_start.size(), 0);
        chk("t6_ss_idle", ss, 1);
        chk("t6_rdata", rdata, 0);
        core_en = 1'b1;
        q_rx.push_back(8'hC3);
        q1.push_back({1'b1, 8'h12});
        wait_rv(1, 100, "t6_rv_after");
        if (q_rv.size() == 1 && q_gnt.size() == 1) begin
            chk("t6_gnt", q_gnt[0], 1);
            chk("t6_tx", q_tx[0], 8'h12);
            chk("t6_rv", q_rv[0], {1'b1, 8'hC3});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
